// File: rtl/int_mul_seq_pkg.sv
// Shared definitions for the iterative multiply unit: RV32M op encodings
// and the IDLE/CALC/FIN state encoding also used by the iterative divider.
package int_mul_seq_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] MUL_OP    = 2'b00;
  localparam logic [OP_W-1:0] MULH_OP   = 2'b01;
  localparam logic [OP_W-1:0] MULHSU_OP = 2'b10;
  localparam logic [OP_W-1:0] MULHU_OP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/int_mul_seq_if.sv
// Request/response bundle between the execute stage (master) and the multiplier (slave).
interface int_mul_seq_if
  import int_mul_seq_pkg::*;
#(
  parameter int XLEN = 32
);
  // Handshake: i_valid is sampled only while o_ready=1 and i_kill=0; there is
  // no queueing. o_valid is a single-cycle pulse qualifying o_result, which
  // then holds until the next pulse. i_kill aborts whatever is in flight.
  logic            i_valid;
  logic [OP_W-1:0] i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_kill;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_a, i_b, i_kill,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_kill,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/int_mul_seq_mul_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// upper half of the accumulator, then shift {carry, acc, mplr} right by one.
module mul_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   mplr,
  input  logic [XLEN-1:0]   mcand,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   mplr_nxt
);
  logic [XLEN:0] sum;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_nxt  = {sum, acc[XLEN-1:1]};
    mplr_nxt = {acc[0], mplr[XLEN-1:1]};
  end
endmodule

// File: rtl/int_mul_seq.sv
// Iterative radix-2 multiplier for MUL/MULH/MULHSU/MULHU: one product bit per
// cycle on magnitudes, sign fixed up in FIN, selected half returned.
module int_mul_seq
  import int_mul_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  int_mul_seq_if.slave        bus,
  output state_t              dbg_state
);
  localparam int CNT_W = $clog2(XLEN);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplr;
  logic [XLEN-1:0]   mplr_step;
  logic [OP_W-1:0]   op;
  logic              neg;
  logic              accept;
  logic              step_en;
  logic              fin_en;
  logic              signed_a;
  logic              signed_b;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_valid && !bus.i_kill) state_nxt = CALC;
      CALC: begin
        if (bus.i_kill)                        state_nxt = IDLE;
        else if (count == CNT_W'(XLEN - 1))    state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state == IDLE);
    accept      = (state == IDLE) && bus.i_valid && !bus.i_kill;
    step_en     = (state == CALC) && !bus.i_kill;
    fin_en      = (state == FIN)  && !bus.i_kill;
  end

  // MUL keeps raw operands: the low word is identical for signed and unsigned.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (bus.i_op)
      MULH_OP:   begin signed_a = 1'b1; signed_b = 1'b1; end
      MULHSU_OP: begin signed_a = 1'b1; signed_b = 1'b0; end
      MUL_OP,
      MULHU_OP:  begin signed_a = 1'b0; signed_b = 1'b0; end
      default:   begin signed_a = 1'b0; signed_b = 1'b0; end
    endcase
    a_mag = (signed_a && bus.i_a[XLEN-1]) ? -bus.i_a : bus.i_a;
    b_mag = (signed_b && bus.i_b[XLEN-1]) ? -bus.i_b : bus.i_b;
  end

  mul_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .mplr     (mplr),
    .mcand    (mcand),
    .acc_nxt  (acc_step),
    .mplr_nxt (mplr_step)
  );

  assign prod = neg ? -acc : acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op       <= MUL_OP;
      neg      <= 1'b0;
      mcand    <= '0;
      mplr     <= '0;
      acc      <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= fin_en;
      if (accept) begin
        op    <= bus.i_op;
        neg   <= (signed_a & bus.i_a[XLEN-1]) ^ (signed_b & bus.i_b[XLEN-1]);
        mcand <= a_mag;
        mplr  <= b_mag;
        acc   <= '0;
        count <= '0;
      end else if (step_en) begin
        acc   <= acc_step;
        mplr  <= mplr_step;
        count <= count + 1'b1;
      end
      if (fin_en) begin
        result_q <= (op == MUL_OP) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign dbg_state    = state;
endmodule
